sram_axi_bridge: RTL
====================

# sram_axi_bridge

Bridges the CPU core's two sram-like ports (instruction fetch, data access) onto a single AXI3 master port. It sits directly downstream of the core's SRAM-style top level, replacing ideal SRAMs with a handshaked bus. The bridge serialises one single-beat transaction at a time; data requests take priority over instruction requests. Address translation (kseg0/kseg1 stripping) happens before this block; addresses pass through unchanged.

## Interface
- AXI_IDW, 4, width of AXI ID fields
- INST_ID, 0, ARID used for instruction reads
- DATA_ID, 1, ARID/AWID used for data reads and writes

Ports:
- clk  in  1  single clock; everything is on its rising edge
- rst  in  1  synchronous, active-high reset
- inst_req, inst_wr  in  1 each  fetch request; inst_wr is always 0 from the core but is honoured
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr, inst_wdata  in  32 each
- inst_rdata  out  32;  inst_addr_ok, inst_data_ok  out  1 each
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same as inst_*
- arid/awid out AXI_IDW; araddr/awaddr out 32; arsize/awsize out 3; arvalid/awvalid out 1; arready/awready in 1
- rid in AXI_IDW; rdata in 32; rvalid in 1; rready out 1
- wdata out 32; wstrb out 4; wlast out 1; wvalid out 1; wready in 1
- bvalid in 1; bready out 1
- Tied constants: arlen/awlen=0, arburst/awburst=2'b01, lock/cache/prot=0, wid=DATA_ID, wlast=1

## Operation
- States: IDLE, AR, R, AW, B.
- IDLE: if data_req, grant data, else if inst_req, grant inst. Granted port's addr_ok=1 (combinational). Latch port, wr, size, addr, wdata. Next state AR if !wr, AW if wr. No request: stay.
- AR: arvalid=1 with latched addr; arsize={1'b0,size}; arid=INST_ID/DATA_ID per granted port. On arready go to R.
- R: rready=1. On rvalid, granted port's data_ok=1, its rdata=AXI rdata (passthrough), go to IDLE. rid is not checked (single outstanding).
- AW: awvalid and wvalid both asserted on entry. Each drops independently after its own handshake. When both done (including same cycle), go to B.
- B: bready=1. On bvalid, granted port's data_ok=1, go to IDLE.
- wstrb: size 0 -> 4'b0001<<addr[1:0]; size 1 -> addr[1]?4'b1100:4'b0011; size 2 -> 4'b1111. wdata passes latched wdata unshifted; the core pre-replicates bytes.
- addr_ok and data_ok never assert for the non-granted port. Both are single-cycle pulses.
- AXI outputs stay stable while valid is high and ready is low.

## Timing
- Reset: state IDLE; arvalid, awvalid, wvalid, rready, bready, both addr_ok, both data_ok = 0; latched registers = 0.
- Reset mid-transaction returns to IDLE with no data_ok. The AXI slave is reset in the same cycle.
- addr_ok is combinational in the request cycle (cycle 0). arvalid/awvalid rise at cycle 1.
- Minimum read: arready at cycle 1, rvalid at cycle 2 -> data_ok at cycle 2. Next addr_ok is possible at cycle 3.
- Minimum write: awready and wready at cycle 1, bvalid at cycle 2 -> data_ok at cycle 2.
- The core must hold req/addr until addr_ok and must not issue a new request on a port before that port's data_ok.

## Test plan
- Inst read 0x1FC00000: arready at cycle 1, rvalid with rdata=0x3C1D0001 at cycle 2 -> inst_addr_ok at cycle 0, arid=0, arsize=2, inst_data_ok with rdata 0x3C1D0001 at cycle 2.
- inst_req and data_req (read 0x00001000) both high in IDLE -> data granted first (arid=1); inst_addr_ok only after data_data_ok, then the inst read completes.
- Byte store addr 0x00000002, wdata 0x5A5A5A5A -> wstrb=4'b0100, awsize=0. Half store addr 0x6 -> wstrb=4'b1100.
- Write where awready comes at cycle 1 and wready at cycle 4 -> awvalid low from cycle 2, wvalid held through cycle 4, bready from cycle 5, data_ok on bvalid.
- arready held low 3 cycles -> arvalid and araddr stable throughout; no data_ok before rvalid.
- rst asserted during R -> next cycle state IDLE, all valids/readies 0, no data_ok. A fresh inst_req then completes normally.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data sram-like ports onto one AXI3 master.
// One single-beat transaction is in flight at a time, and data requests win arbitration.
module sram_axi_bridge #(
  parameter int AXI_IDW = 4,
  parameter int INST_ID = 0,
  parameter int DATA_ID = 1
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               inst_req,
  input  logic               inst_wr,
  input  logic [1:0]         inst_size,
  input  logic [31:0]        inst_addr,
  input  logic [31:0]        inst_wdata,
  output logic [31:0]        inst_rdata,
  output logic               inst_addr_ok,
  output logic               inst_data_ok,

  input  logic               data_req,
  input  logic               data_wr,
  input  logic [1:0]         data_size,
  input  logic [31:0]        data_addr,
  input  logic [31:0]        data_wdata,
  output logic [31:0]        data_rdata,
  output logic               data_addr_ok,
  output logic               data_data_ok,

  output logic [AXI_IDW-1:0] arid,
  output logic [31:0]        araddr,
  output logic [3:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic [1:0]         arlock,
  output logic [3:0]         arcache,
  output logic [2:0]         arprot,
  output logic               arvalid,
  input  logic               arready,

  input  logic [AXI_IDW-1:0] rid,
  input  logic [31:0]        rdata,
  input  logic               rvalid,
  output logic               rready,

  output logic [AXI_IDW-1:0] awid,
  output logic [31:0]        awaddr,
  output logic [3:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic [1:0]         awlock,
  output logic [3:0]         awcache,
  output logic [2:0]         awprot,
  output logic               awvalid,
  input  logic               awready,

  output logic [AXI_IDW-1:0] wid,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,

  input  logic               bvalid,
  output logic               bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW, B} stateT;

  localparam logic [AXI_IDW-1:0] INST_IDV = AXI_IDW'(INST_ID);
  localparam logic [AXI_IDW-1:0] DATA_IDV = AXI_IDW'(DATA_ID);

  stateT       state;
  stateT       nextState;
  logic        grantData;
  logic        wrLat;
  logic [1:0]  sizeLat;
  logic [31:0] addrLat;
  logic [31:0] wdataLat;
  logic        awDone;
  logic        wDone;
  logic        awFire;
  logic        wFire;
  logic        unusedRid;

  // Byte lanes for a store; the core has already replicated the data across lanes.
  function automatic logic [3:0] strbFor(input logic [1:0] size, input logic [1:0] offs);
    case (size)
      2'd0:    strbFor = 4'b0001 << offs;
      2'd1:    strbFor = offs[1] ? 4'b1100 : 4'b0011;
      default: strbFor = 4'b1111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grantData <= 1'b0;
      wrLat     <= 1'b0;
      sizeLat   <= 2'd0;
      addrLat   <= 32'd0;
      wdataLat  <= 32'd0;
      awDone    <= 1'b0;
      wDone     <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE && (data_req || inst_req)) begin
        grantData <= data_req;
        wrLat     <= data_req ? data_wr    : inst_wr;
        sizeLat   <= data_req ? data_size  : inst_size;
        addrLat   <= data_req ? data_addr  : inst_addr;
        wdataLat  <= data_req ? data_wdata : inst_wdata;
        awDone    <= 1'b0;
        wDone     <= 1'b0;
      end else begin
        if (awFire) awDone <= 1'b1;
        if (wFire)  wDone  <= 1'b1;
      end
    end
  end

  always_comb begin
    nextState    = state;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    awFire       = 1'b0;
    wFire        = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state)
      IDLE: begin
        if (data_req) begin
          data_addr_ok = !rst;
          nextState    = data_wr ? AW : AR;
        end else if (inst_req) begin
          inst_addr_ok = !rst;
          nextState    = inst_wr ? AW : AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) nextState = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) begin
          data_data_ok = grantData && !rst;
          inst_data_ok = !grantData && !rst;
          nextState    = IDLE;
        end
      end
      AW: begin
        // Address and data channels complete independently, possibly in one cycle.
        awvalid = !awDone;
        wvalid  = !wDone;
        awFire  = !awDone && awready;
        wFire   = !wDone && wready;
        if ((awDone || awFire) && (wDone || wFire)) nextState = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) begin
          data_data_ok = grantData && !rst;
          inst_data_ok = !grantData && !rst;
          nextState    = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign arid    = grantData ? DATA_IDV : INST_IDV;
  assign awid    = grantData ? DATA_IDV : INST_IDV;
  assign araddr  = addrLat;
  assign awaddr  = addrLat;
  assign arsize  = {1'b0, sizeLat};
  assign awsize  = {1'b0, sizeLat};
  assign wdata   = wdataLat;
  assign wstrb   = strbFor(sizeLat, addrLat[1:0]);
  assign wid     = DATA_IDV;
  assign wlast   = 1'b1;

  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  // Only one read is ever outstanding, so the returned ID carries no information.
  assign inst_rdata = rdata;
  assign data_rdata = rdata;
  assign unusedRid  = ^{rid, wrLat};

endmodule
